mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined CPU. It serializes requests through a small FSM, drives the memory strobe/address/data, returns read data with one-cycle ready pulses, and exports stall signals used by the hazard logic to freeze the PC, IF/ID and the later pipeline registers.

## Interface
- WORD, 32, data/address width
- MAX_STREAK, 4, consecutive data grants allowed while a fetch waits (used only with ARB_FAIR_EN)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_req  in  1  fetch request, held high until i_ready
- i_addr  in  WORD  fetch address (current PC), stable while i_req
- i_rdata  out  WORD  fetched instruction, valid when i_ready
- i_ready  out  1  one-cycle pulse: fetch complete
- d_req  in  1  data request, held high until d_ready
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  WORD  data address (EX/MEM ALU result)
- d_wdata  in  WORD  store data
- d_rdata  out  WORD  load data, valid when d_ready
- d_ready  out  1  one-cycle pulse: data access complete
- stall_if  out  1  i_req & ~i_ready (combinational)
- stall_mem  out  1  d_req & ~d_ready (combinational)
- mem_valid  out  1  one-cycle start strobe to memory
- mem_we  out  1  write enable, held for whole access
- mem_addr  out  WORD  address, held for whole access
- mem_wdata  out  WORD  write data, held for whole access
- mem_ack  in  1  memory completion pulse; carries mem_rdata for reads
- mem_rdata  in  WORD  memory read data, sampled on mem_ack

## Operation
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: d_req wins over i_req (older instruction first) unless fairness override (see Configuration). Winner latched: mem_we/mem_addr/mem_wdata loaded (fetch: we=0, wdata=0), go to I_BUSY or D_BUSY. No request: stay.
- I_BUSY/D_BUSY: mem_valid=1 only in first cycle of the state; mem_we/addr/wdata held constant. On mem_ack=1: capture mem_rdata into i_rdata (I_BUSY) or d_rdata (D_BUSY load only; stores leave d_rdata unchanged), go to RESP.
- RESP: i_ready or d_ready (matching owner) = 1 for exactly this cycle; requests ignored; go to IDLE. Prevents regranting a request the requester drops at this edge.
- mem_ack in IDLE or RESP: ignored.
- i_rdata/d_rdata hold last captured value until next capture.
- stall outputs combinational so hazard unit freezes the stage in the same cycle.

## Timing
- Reset values: state IDLE, i_ready=d_ready=0, mem_valid=mem_we=0, mem_addr=mem_wdata=0, i_rdata=d_rdata=0, streak counter 0.
- Request seen at edge N (state IDLE) -> BUSY with mem_valid at cycle N+1; mem_ack may arrive in cycle N+1 or later; ack at cycle K -> ready pulse in cycle K+1 -> IDLE at K+2. Minimum 3 cycles from request sample to ready; back-to-back throughput one access per 3 cycles minimum.
- Simultaneous i_req and d_req in IDLE: one grant per arbitration; loser waits, its stall stays high.
- Reset asserted mid-access: immediate return to IDLE with reset values; in-flight access abandoned, a late mem_ack is ignored; ready never pulses for it.
- Requester dropping req before ready is illegal; behaviour unspecified.

## Configuration
- ARB_FAIR_EN defined: saturating counter (width clog2(MAX_STREAK+1)) increments on each data grant made while i_req is high, clears on any fetch grant. When counter == MAX_STREAK and both requests pending in IDLE, fetch is granted. Counter resets to 0.
- ARB_FAIR_EN undefined: strict data priority, counter not instantiated.

## Test plan
- Single fetch: i_req=1, i_addr=0x10, memory acks 2 cycles after mem_valid with 0x00500093 -> mem_valid one cycle, mem_addr=0x10, mem_we=0, i_ready one pulse, i_rdata=0x00500093, stall_if high until that pulse.
- Store then load: d_req store addr 0x100 data 0xDEADBEEF, then load 0x100 from model -> mem_we=1 for store access only, d_ready pulses twice, d_rdata=0xDEADBEEF after load, unchanged after store.
- Contention: i_req and d_req both rise same cycle -> data granted first, fetch granted in the IDLE after data RESP; stall_if high throughout data access.
- Fairness (ARB_FAIR_EN, MAX_STREAK=4): i_req held, d_req continuously re-asserted -> exactly 4 data grants then one fetch grant; without macro, fetch never granted while d_req held.
- Reset mid-access: assert reset in D_BUSY before ack, then ack one cycle after release -> all outputs zero, state IDLE, no d_ready pulse, next request served normally.
- Stray ack: mem_ack pulsed in IDLE with no requests -> no ready, no state change, rdata outputs unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between IF fetch and MEM load/store
// Optional fetch-starvation guard is enabled by defining ARB_FAIR_EN.
module mem_port_arbiter #(
   parameter int WORD       = 32,
   parameter int MAX_STREAK = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [WORD-1:0] i_addr,
   output logic [WORD-1:0] i_rdata,
   output logic            i_ready,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [WORD-1:0] d_addr,
   input  logic [WORD-1:0] d_wdata,
   output logic [WORD-1:0] d_rdata,
   output logic            d_ready,
   output logic            stall_if,
   output logic            stall_mem,
   output logic            mem_valid,
   output logic            mem_we,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [WORD-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

   state_t          state_q, state_d;
   logic            owner_data_q, owner_data_d;
   logic            mem_valid_q, mem_valid_d;
   logic            mem_we_q, mem_we_d;
   logic [WORD-1:0] mem_addr_q, mem_addr_d;
   logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
   logic [WORD-1:0] i_rdata_q, i_rdata_d;
   logic [WORD-1:0] d_rdata_q, d_rdata_d;
   logic            grant_i, grant_d;

`ifdef ARB_FAIR_EN
   localparam int SW = $clog2(MAX_STREAK + 1);

   logic [SW-1:0] streak_q, streak_d;
   logic          fetch_turn;

   assign fetch_turn = (streak_q == SW'(MAX_STREAK));

   always_comb begin
      grant_i = (state_q == IDLE) && i_req && (!d_req || fetch_turn);
      grant_d = (state_q == IDLE) && d_req && !grant_i;
   end

   // Counts data grants that overtook a waiting fetch; saturates at MAX_STREAK.
   always_comb begin
      streak_d = streak_q;
      if (grant_i)
         streak_d = '0;
      else if (grant_d && i_req && !fetch_turn)
         streak_d = streak_q + SW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         streak_q <= '0;
      else
         streak_q <= streak_d;
   end
`else
   always_comb begin
      grant_d = (state_q == IDLE) && d_req;
      grant_i = (state_q == IDLE) && i_req && !d_req;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_data_q <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_data_q <= owner_data_d;
         mem_valid_q  <= mem_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_i)
               state_d = I_BUSY;
            else if (grant_d)
               state_d = D_BUSY;
         end
         I_BUSY, D_BUSY: begin
            if (mem_ack)
               state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Access attributes are latched at grant and held until the next grant.
   always_comb begin
      owner_data_d = owner_data_q;
      mem_valid_d  = grant_i || grant_d;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      if (grant_d) begin
         owner_data_d = 1'b1;
         mem_we_d     = d_we;
         mem_addr_d   = d_addr;
         mem_wdata_d  = d_wdata;
      end else if (grant_i) begin
         owner_data_d = 1'b0;
         mem_we_d     = 1'b0;
         mem_addr_d   = i_addr;
         mem_wdata_d  = '0;
      end
      if (state_q == I_BUSY && mem_ack)
         i_rdata_d = mem_rdata;
      if (state_q == D_BUSY && mem_ack && !mem_we_q)
         d_rdata_d = mem_rdata;
   end

   always_comb begin
      i_ready   = (state_q == RESP) && !owner_data_q;
      d_ready   = (state_q == RESP) && owner_data_q;
      stall_if  = i_req && !i_ready;
      stall_mem = d_req && !d_ready;
      mem_valid = mem_valid_q;
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      i_rdata   = i_rdata_q;
      d_rdata   = d_rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Fairness expectations follow ARB_FAIR_EN when it is defined for the build.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_ready, d_ready, stall_if, stall_mem, mem_valid, mem_we;
   logic [31:0] model_word;
   logic        exp_fetch;
   int          n_cmp = 0;
   int          n_err = 0;

`ifdef ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.WORD(32), .MAX_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; model_word = '0;
      exp_fetch = 1'b0;

      step();
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      step();
      reset = 1'b0;
      step();

      // single fetch, ack two cycles after the strobe
      i_req = 1'b1; i_addr = 32'h10;
      #1 chk("f_stall_req", stall_if, 1);
      step();
      chk("f_valid", mem_valid, 1);
      chk("f_addr", mem_addr, 32'h10);
      chk("f_we", mem_we, 0);
      chk("f_ready_early", i_ready, 0);
      chk("f_stall_busy", stall_if, 1);
      step();
      chk("f_valid_once", mem_valid, 0);
      chk("f_addr_held", mem_addr, 32'h10);
      step();
      chk("f_stall_wait", stall_if, 1);
      mem_ack = 1'b1; mem_rdata = 32'h00500093;
      step();
      mem_ack = 1'b0;
      chk("f_ready", i_ready, 1);
      chk("f_rdata", i_rdata, 32'h00500093);
      chk("f_stall_done", stall_if, 0);
      i_req = 1'b0;
      step();
      chk("f_ready_pulse", i_ready, 0);
      chk("f_rdata_hold", i_rdata, 32'h00500093);

      // store, then load back through the bench memory word
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      step();
      chk("st_valid", mem_valid, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 32'h100);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      chk("st_stall", stall_mem, 1);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      model_word = mem_wdata;
      step();
      mem_ack = 1'b0;
      chk("st_ready", d_ready, 1);
      chk("st_rdata_keep", d_rdata, 0);
      d_req = 1'b0;
      step();
      d_req = 1'b1; d_we = 1'b0;
      chk("st_ready_pulse", d_ready, 0);
      step();
      chk("ld_valid", mem_valid, 1);
      chk("ld_we", mem_we, 0);
      chk("ld_addr", mem_addr, 32'h100);
      step();
      mem_ack = 1'b1; mem_rdata = model_word;
      step();
      mem_ack = 1'b0;
      chk("ld_ready", d_ready, 1);
      chk("ld_rdata", d_rdata, 32'hDEADBEEF);
      d_req = 1'b0;
      step();

      // simultaneous requests: data first, fetch in the following IDLE
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      step();
      chk("ct_valid_d", mem_valid, 1);
      chk("ct_addr_d", mem_addr, 32'h200);
      chk("ct_stall_if", stall_if, 1);
      chk("ct_stall_mem", stall_mem, 1);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
      step();
      mem_ack = 1'b0;
      chk("ct_d_ready", d_ready, 1);
      chk("ct_i_ready", i_ready, 0);
      chk("ct_d_rdata", d_rdata, 32'hCAFE0001);
      chk("ct_stall_if_resp", stall_if, 1);
      d_req = 1'b0;
      step();
      chk("ct_idle_valid", mem_valid, 0);
      chk("ct_idle_stall", stall_if, 1);
      step();
      chk("ct_valid_i", mem_valid, 1);
      chk("ct_addr_i", mem_addr, 32'h20);
      chk("ct_we_i", mem_we, 0);
      mem_ack = 1'b1; mem_rdata = 32'h11112222;
      step();
      mem_ack = 1'b0;
      chk("ct_i_ready2", i_ready, 1);
      chk("ct_i_rdata", i_rdata, 32'h11112222);
      i_req = 1'b0;
      step();

      // fetch held against a continuously requesting data port
      i_req = 1'b1; i_addr = 32'h30;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      for (int k = 0; k < 5; k++) begin
         step();
         exp_fetch = FAIR && (k == 4);
         chk($sformatf("fr_valid_%0d", k), mem_valid, 1);
         chk($sformatf("fr_addr_%0d", k), mem_addr, exp_fetch ? 32'h30 : 32'h300);
         chk($sformatf("fr_stall_if_%0d", k), stall_if, 1);
         mem_ack = 1'b1; mem_rdata = 32'hA0 + k;
         step();
         mem_ack = 1'b0;
         chk($sformatf("fr_d_ready_%0d", k), d_ready, !exp_fetch);
         chk($sformatf("fr_i_ready_%0d", k), i_ready, exp_fetch);
         if (k == 4) begin
            d_req = 1'b0;
            if (exp_fetch) i_req = 1'b0;
         end
         step();
      end
`ifndef ARB_FAIR_EN
      step();
      chk("fr_late_addr", mem_addr, 32'h30);
      chk("fr_late_valid", mem_valid, 1);
      mem_ack = 1'b1; mem_rdata = 32'h0000BEEF;
      step();
      mem_ack = 1'b0;
      chk("fr_late_ready", i_ready, 1);
      chk("fr_late_rdata", i_rdata, 32'h0000BEEF);
      i_req = 1'b0;
      step();
`endif

      // reset during a store, late ack after release
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h55AA55AA;
      step();
      chk("rm_valid", mem_valid, 1);
      chk("rm_we", mem_we, 1);
      reset = 1'b1; d_req = 1'b0;
      #1;
      chk("rm_valid0", mem_valid, 0);
      chk("rm_we0", mem_we, 0);
      chk("rm_addr0", mem_addr, 0);
      chk("rm_wdata0", mem_wdata, 0);
      chk("rm_i_rdata0", i_rdata, 0);
      chk("rm_d_rdata0", d_rdata, 0);
      chk("rm_d_ready0", d_ready, 0);
      step();
      reset = 1'b0;
      step();
      mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
      step();
      mem_ack = 1'b0;
      chk("rm_late_ready", d_ready, 0);
      chk("rm_late_valid", mem_valid, 0);
      chk("rm_late_rdata", d_rdata, 0);
      step();
      chk("rm_late_ready2", d_ready, 0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      step();
      chk("rm_next_valid", mem_valid, 1);
      chk("rm_next_addr", mem_addr, 32'h500);
      mem_ack = 1'b1; mem_rdata = 32'h13572468;
      step();
      mem_ack = 1'b0;
      chk("rm_next_ready", d_ready, 1);
      chk("rm_next_rdata", d_rdata, 32'h13572468);
      d_req = 1'b0;
      step();

      // stray ack while idle
      mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      step();
      mem_ack = 1'b0;
      chk("sa_i_ready", i_ready, 0);
      chk("sa_d_ready", d_ready, 0);
      chk("sa_valid", mem_valid, 0);
      step();
      chk("sa_i_ready2", i_ready, 0);
      chk("sa_d_ready2", d_ready, 0);
      chk("sa_i_rdata", i_rdata, 0);
      chk("sa_d_rdata", d_rdata, 32'h13572468);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
